// File: rtl/ycbcr_buf_ctrl.sv
// ycbcr_buf_ctrl: frame-level sequencer for the three-plane YCbCr pixel buffer.
// A start command latches a frame length. The buffer is then filled from the
// colour-conversion stage and drained to the transform stage, one pixel per
// accepted handshake. The buffer's internal counters are cleared by holding
// its enable low, which happens in IDLE and DONE.
module ycbcr_buf_ctrl #(
   parameter int DEPTH = 1048576,
   parameter int CNT_W = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic             snk_ready,
   output logic             snk_valid,
   output logic             mem_enable,
   output logic             mem_en_write,
   output logic             mem_en_read,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count,
   output logic             busy,
   output logic             done,
   output logic             err_len
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MaxLen = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] One    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] wr_count_q, wr_count_d;
   logic [CNT_W-1:0] rd_count_q, rd_count_d;
   logic             err_len_q, err_len_d;

   // State, frame length, progress counters and the error pulse register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wr_count_q <= '0;
         rd_count_q <= '0;
         err_len_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
         err_len_q  <= err_len_d;
      end
   end

   // Next-state and handshake logic; abort masks both handshakes and overrides every transition
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      wr_count_d   = wr_count_q;
      rd_count_d   = rd_count_q;
      err_len_d    = 1'b0;
      src_ready    = 1'b0;
      snk_valid    = 1'b0;
      mem_enable   = 1'b0;
      mem_en_write = 1'b0;
      mem_en_read  = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (frame_len == '0) begin
                  len_d      = '0;
                  wr_count_d = '0;
                  rd_count_d = '0;
                  state_d    = DONE;
               end else if (frame_len > MaxLen) begin
                  err_len_d = 1'b1;
               end else begin
                  len_d      = frame_len;
                  wr_count_d = '0;
                  rd_count_d = '0;
                  state_d    = FILL;
               end
            end
         end

         FILL: begin
            mem_enable   = 1'b1;
            src_ready    = (wr_count_q < len_q) && !abort;
            mem_en_write = src_valid && src_ready;
            if (mem_en_write) begin
               wr_count_d = wr_count_q + One;
               if (wr_count_d == len_q) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            mem_enable  = 1'b1;
            snk_valid   = (rd_count_q < len_q) && !abort;
            mem_en_read = snk_valid && snk_ready;
            if (mem_en_read) begin
               rd_count_d = rd_count_q + One;
               if (rd_count_d == len_q) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            done    = !abort;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         state_d = IDLE;
      end
   end

   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;
   assign err_len  = err_len_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ycbcr_buf_ctrl.sv
// tb_ycbcr_buf_ctrl: directed bench for the YCbCr buffer controller.
// A small behavioural buffer writes on the rising edge and reads on the
// falling edge, so pixel order through a whole frame can be checked.
module tb_ycbcr_buf_ctrl;

   localparam int CNT_W = 21;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] frame_len;
   logic             src_valid;
   logic             src_ready;
   logic             snk_ready;
   logic             snk_valid;
   logic             mem_enable;
   logic             mem_en_write;
   logic             mem_en_read;
   logic [CNT_W-1:0] wr_count;
   logic [CNT_W-1:0] rd_count;
   logic             busy;
   logic             done;
   logic             err_len;

   logic [31:0] pixIn;
   logic [31:0] pixOut;
   logic [31:0] bufMem [0:15];
   logic [3:0]  wrPtr;
   logic [3:0]  rdPtr;

   int checks;
   int errors;

   ycbcr_buf_ctrl #(.DEPTH(1048576), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .frame_len    (frame_len),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .snk_ready    (snk_ready),
      .snk_valid    (snk_valid),
      .mem_enable   (mem_enable),
      .mem_en_write (mem_en_write),
      .mem_en_read  (mem_en_read),
      .wr_count     (wr_count),
      .rd_count     (rd_count),
      .busy         (busy),
      .done         (done),
      .err_len      (err_len)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Buffer write side: capture on the rising edge, pointer cleared while disabled
   always @(posedge clk) begin
      if (!mem_enable) begin
         wrPtr <= '0;
      end else if (mem_en_write) begin
         bufMem[wrPtr] <= pixIn;
         wrPtr         <= wrPtr + 4'd1;
      end
   end

   // Buffer read side: fetch on the falling edge, pointer cleared while disabled
   always @(negedge clk) begin
      if (!mem_enable) begin
         rdPtr <= '0;
      end else if (mem_en_read) begin
         pixOut <= bufMem[rdPtr];
         rdPtr  <= rdPtr + 4'd1;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [CNT_W-1:0] len, input logic sv, input logic sr);
      start     = st;
      frame_len = len;
      src_valid = sv;
      snk_ready = sr;
   endtask

   // Check the pixel fetched on the falling edge of the current cycle
   task automatic checkReadback(input string tag, input logic [31:0] expected);
      @(negedge clk);
      #1;
      checkOutput(tag, pixOut, expected);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      abort  = 1'b0;
      pixIn  = '0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);

      // ---- 1: reset state, then a 4-pixel frame streamed at full rate
      #12;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_err", {31'd0, err_len}, 32'd0);
      checkOutput("rst_wr", 32'(wr_count), 32'd0);
      checkOutput("rst_rd", 32'(rd_count), 32'd0);
      checkOutput("rst_en", {31'd0, mem_enable}, 32'd0);
      checkOutput("rst_srdy", {31'd0, src_ready}, 32'd0);
      checkOutput("rst_svld", {31'd0, snk_valid}, 32'd0);
      rst_n = 1'b1;
      tick();
      applyStimulus(1'b1, 21'd4, 1'b1, 1'b1);
      pixIn = 32'h1000;
      settle();
      checkOutput("t1_idle_we", {31'd0, mem_en_write}, 32'd0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pixIn = 32'h1000 + 32'(i);
         settle();
         checkOutput("t1_fill_we", {31'd0, mem_en_write}, 32'd1);
         checkOutput("t1_fill_en", {31'd0, mem_enable}, 32'd1);
         tick();
         checkOutput("t1_wr", 32'(wr_count), 32'(i + 1));
      end
      checkOutput("t1_drain_we", {31'd0, mem_en_write}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t1_svld", {31'd0, snk_valid}, 32'd1);
         checkOutput("t1_re", {31'd0, mem_en_read}, 32'd1);
         checkReadback("t1_pix", 32'h1000 + 32'(i));
         tick();
         checkOutput("t1_rd", 32'(rd_count), 32'(i + 1));
      end
      checkOutput("t1_done", {31'd0, done}, 32'd1);
      checkOutput("t1_done_en", {31'd0, mem_enable}, 32'd0);
      tick();
      checkOutput("t1_done_gone", {31'd0, done}, 32'd0);
      checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("t1_wr_hold", 32'(wr_count), 32'd4);

      // ---- 2: 3-pixel frame with src_valid toggling, FILL lasts 5 cycles
      applyStimulus(1'b1, 21'd3, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      checkOutput("t2_wr_clr", 32'(wr_count), 32'd0);
      checkOutput("t2_rd_clr", 32'(rd_count), 32'd0);
      src_valid = 1'b1; pixIn = 32'h200; settle();
      checkOutput("t2_we1", {31'd0, mem_en_write}, 32'd1);
      tick(); checkOutput("t2_wr1", 32'(wr_count), 32'd1);
      src_valid = 1'b0; settle();
      checkOutput("t2_we0", {31'd0, mem_en_write}, 32'd0);
      tick(); checkOutput("t2_wr1h", 32'(wr_count), 32'd1);
      src_valid = 1'b1; pixIn = 32'h201;
      tick(); checkOutput("t2_wr2", 32'(wr_count), 32'd2);
      src_valid = 1'b0;
      tick(); checkOutput("t2_wr2h", 32'(wr_count), 32'd2);
      checkOutput("t2_still_fill", {31'd0, src_ready}, 32'd1);
      src_valid = 1'b1; pixIn = 32'h202;
      tick(); checkOutput("t2_wr3", 32'(wr_count), 32'd3);
      src_valid = 1'b0;
      checkOutput("t2_drain", {31'd0, snk_valid}, 32'd1);

      // ---- 3: drain with snk_ready low for two cycles mid-frame
      snk_ready = 1'b1; settle();
      checkReadback("t3_pix0", 32'h200);
      tick(); checkOutput("t3_rd1", 32'(rd_count), 32'd1);
      snk_ready = 1'b0; settle();
      checkOutput("t3_re_low", {31'd0, mem_en_read}, 32'd0);
      tick(); checkOutput("t3_rd_hold1", 32'(rd_count), 32'd1);
      settle();
      checkOutput("t3_re_low2", {31'd0, mem_en_read}, 32'd0);
      tick(); checkOutput("t3_rd_hold2", 32'(rd_count), 32'd1);
      snk_ready = 1'b1; settle();
      checkReadback("t3_pix1", 32'h201);
      tick(); checkOutput("t3_rd2", 32'(rd_count), 32'd2);
      checkReadback("t3_pix2", 32'h202);
      tick(); checkOutput("t3_rd3", 32'(rd_count), 32'd3);
      checkOutput("t3_done", {31'd0, done}, 32'd1);
      tick();
      checkOutput("t3_idle", {31'd0, busy}, 32'd0);

      // ---- 4: zero-length frame goes straight to DONE
      applyStimulus(1'b1, 21'd0, 1'b1, 1'b1);
      tick();
      start = 1'b0;
      checkOutput("t4_done", {31'd0, done}, 32'd1);
      checkOutput("t4_busy", {31'd0, busy}, 32'd1);
      checkOutput("t4_we", {31'd0, mem_en_write}, 32'd0);
      checkOutput("t4_re", {31'd0, mem_en_read}, 32'd0);
      checkOutput("t4_wr", 32'(wr_count), 32'd0);
      tick();
      checkOutput("t4_idle_done", {31'd0, done}, 32'd0);
      checkOutput("t4_idle_busy", {31'd0, busy}, 32'd0);

      // ---- 5: oversize frame rejected; start during FILL ignored
      applyStimulus(1'b1, 21'd1048577, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      checkOutput("t5_err", {31'd0, err_len}, 32'd1);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      tick();
      checkOutput("t5_err_gone", {31'd0, err_len}, 32'd0);
      applyStimulus(1'b1, 21'd1048576, 1'b0, 1'b0);
      tick();
      checkOutput("t5_max_ok", {31'd0, busy}, 32'd1);
      checkOutput("t5_max_err", {31'd0, err_len}, 32'd0);
      abort = 1'b1; start = 1'b0;
      tick();
      abort = 1'b0;
      applyStimulus(1'b1, 21'd5, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 21'd2, 1'b1, 1'b0);
      tick();
      start = 1'b0;
      checkOutput("t5_wr1", 32'(wr_count), 32'd1);
      tick();
      tick();
      checkOutput("t5_wr3", 32'(wr_count), 32'd3);
      checkOutput("t5_len_kept", {31'd0, src_ready}, 32'd1);
      src_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // ---- 6: abort at wr_count=2 of 8, then reset mid-DRAIN, then a clean frame
      applyStimulus(1'b1, 21'd8, 1'b1, 1'b0);
      tick();
      start = 1'b0;
      tick();
      tick();
      checkOutput("t6_wr2", 32'(wr_count), 32'd2);
      abort = 1'b1; settle();
      checkOutput("t6_abort_we", {31'd0, mem_en_write}, 32'd0);
      tick();
      abort = 1'b0;
      checkOutput("t6_abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_abort_en", {31'd0, mem_enable}, 32'd0);
      checkOutput("t6_abort_done", {31'd0, done}, 32'd0);
      checkOutput("t6_abort_wr", 32'(wr_count), 32'd2);
      tick();
      checkOutput("t6_no_late_done", {31'd0, done}, 32'd0);
      applyStimulus(1'b1, 21'd3, 1'b1, 1'b0);
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      src_valid = 1'b0;
      checkOutput("t6_in_drain", {31'd0, snk_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_rst_en", {31'd0, mem_enable}, 32'd0);
      checkOutput("t6_rst_svld", {31'd0, snk_valid}, 32'd0);
      checkOutput("t6_rst_wr", 32'(wr_count), 32'd0);
      checkOutput("t6_rst_rd", 32'(rd_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(1'b1, 21'd2, 1'b1, 1'b1);
      pixIn = 32'h300;
      tick();
      start = 1'b0;
      tick();
      pixIn = 32'h301;
      tick();
      checkOutput("t6_f_wr", 32'(wr_count), 32'd2);
      checkReadback("t6_pix0", 32'h300);
      tick();
      checkReadback("t6_pix1", 32'h301);
      tick();
      checkOutput("t6_f_rd", 32'(rd_count), 32'd2);
      checkOutput("t6_f_done", {31'd0, done}, 32'd1);
      tick();
      checkOutput("t6_f_idle", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ycbcr_buf_ctrl.md
Name: ycbcr_buf_ctrl

Overview:
Frame-level controller for the YCbCr pixel buffer (three 32-bit planes, 1M words each, with internal write/read counters that clear while its enable is low).
Accepts a start command with a frame length, then sequences the buffer in two phases:
- fill phase: valid/ready handshake from the colour-conversion stage;
- drain phase: valid/ready handshake to the downstream transform stage.
Drives the buffer's enable, en_write and en_read, and reports progress, completion and errors.

Parameters:
DEPTH, 1048576, buffer depth in words; largest legal frame_len.
CNT_W, 21, width of frame_len and the counters; must hold DEPTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle command pulse; honoured only in IDLE.
abort  input  1  synchronous abort; returns to IDLE from any state.
frame_len  input  CNT_W  pixels per frame; sampled when start is honoured.
src_valid  input  1  upstream pixel (Y/Cb/Cr) present on the buffer data inputs.
src_ready  output  1  controller accepts a pixel this cycle.
snk_ready  input  1  downstream can take a pixel this cycle.
snk_valid  output  1  buffer outputs carry a valid pixel at the next rising edge.
mem_enable  output  1  buffer enable; low clears the buffer's internal counters.
mem_en_write  output  1  buffer write strobe.
mem_en_read  output  1  buffer read strobe.
wr_count  output  CNT_W  pixels written this frame.
rd_count  output  CNT_W  pixels read this frame.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when the frame has fully drained.
err_len  output  1  one-cycle pulse when a start is rejected for an illegal length.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; len_q, wr_count and rd_count = 0; busy, done, err_len = 0.
  - Combinational outputs src_ready, snk_valid, mem_en_write, mem_en_read and mem_enable are therefore 0 in IDLE.
  - Reset mid-frame abandons the frame. mem_enable falls immediately, so the buffer counters clear.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - mem_enable=0; counters held at 0.
  - start with frame_len in 1..DEPTH: latch len_q=frame_len, go to FILL.
  - start with frame_len=0: go straight to DONE.
  - start with frame_len>DEPTH: pulse err_len for one cycle, stay in IDLE.
- FILL:
  - mem_enable=1; src_ready=1 while wr_count<len_q.
  - mem_en_write = src_valid & src_ready (combinational). The buffer captures the pixel on the same rising edge, and wr_count increments on that edge.
  - Transition to DRAIN on the edge where wr_count reaches len_q. No idle cycle is inserted.
- DRAIN:
  - mem_enable=1; snk_valid=1 while rd_count<len_q.
  - mem_en_read = snk_valid & snk_ready (combinational).
  - The buffer fetches on the falling edge inside that cycle. Data is stable at the following rising edge, when the sink samples it and rd_count increments.
  - Transition to DONE on the edge where rd_count reaches len_q.
- DONE:
  - done=1 for exactly one cycle; mem_enable=0, which clears the buffer counters.
  - Next state is IDLE. wr_count and rd_count keep their final values until the next start is honoured, then clear to 0.
- abort:
  - In FILL, DRAIN or DONE: go to IDLE next edge with no done pulse; mem_enable=0 from that edge.
  - abort has priority over start and over phase completion in the same cycle.
- start while busy: ignored; no error is raised.
- Back-to-back frames: a start in the cycle after DONE is legal and is accepted in IDLE.
- Widths: counters are CNT_W bits with no wrap. They saturate at len_q by construction.
- mem_en_write and mem_en_read are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
1. Reset, then start with frame_len=4 and src_valid held high.
   - Required: mem_en_write high for exactly 4 cycles; wr_count steps 1,2,3,4.
   - With snk_ready=1: snk_valid for 4 cycles, rd_count reaches 4, done pulses 1 cycle later, then busy=0.
2. FILL with src_valid toggling 1,0,1,0 and frame_len=3.
   - Required: wr_count increments only on valid cycles; FILL lasts 5 cycles.
   - Buffer readback order equals write order.
3. DRAIN with snk_ready low for 2 cycles mid-frame.
   - Required: mem_en_read low while snk_ready is low; rd_count holds; no pixel is skipped or duplicated; done still follows the last read.
4. Start with frame_len=0.
   - Required: state goes IDLE to DONE; done pulses; mem_en_write and mem_en_read never assert.
5. Start with frame_len=1048577.
   - Required: err_len pulses 1 cycle; busy stays 0.
   - A start during FILL is ignored and wr_count is unaffected.
6. Abort, then reset.
   - Abort at wr_count=2 of 8: IDLE next edge; mem_enable=0; no done pulse.
   - A rst_n low pulse mid-DRAIN: all outputs 0 immediately.
   - A following start with frame_len=2 completes normally.
